// File: rtl/collect_ifft.sv
// collect_ifft: captures IFFT output frames per output channel, keeps the scaled/rounded real part
// and writes it to the output buffer at {ochnl, beat}. Define IFFT_SAT_EN to saturate instead of truncate.
module collect_ifft #(
  parameter int DATALEN = 16,
  parameter int OUTLEN  = 8,
  parameter int PARATIL = 9,
  parameter int FFTCHNL = 8,
  parameter int NUMOCH  = 64,
  parameter int SCALESH = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 collstart,
  input  logic                                 ifftoutnext,
  input  logic [PARATIL*FFTCHNL*2*DATALEN-1:0] ifftout,
  output logic                                 wren,
  output logic [11:0]                          wraddr,
  output logic [PARATIL*FFTCHNL*OUTLEN-1:0]    wrdata,
  output logic                                 ifftdone,
  output logic                                 overrun
);
  localparam int NW = PARATIL * FFTCHNL;
  localparam int RND_I = (1 << SCALESH) >> 1;
  localparam logic signed [DATALEN:0] RND = RND_I[DATALEN:0];
  localparam logic [5:0] LAST_CH = 6'(NUMOCH - 1);
`ifdef IFFT_SAT_EN
  localparam logic signed [DATALEN:0] SAT_HI = (DATALEN+1)'((1 << (OUTLEN - 1)) - 1);
  localparam logic signed [DATALEN:0] SAT_LO = ~SAT_HI;
`endif

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [5:0]               ochnl_q, ochnl_d;
  logic [2:0]               beat_q, beat_d;
  logic                     wren_q, wren_d;
  logic [11:0]              wraddr_q, wraddr_d;
  logic [NW*OUTLEN-1:0]     wrdata_q, wrdata_d;
  logic                     ifftdone_q, ifftdone_d;
  logic                     overrun_q, overrun_d;
  logic [NW*DATALEN-1:0]    unused_im;

  // Sum carried one bit wider than re so the rounding offset can never overflow.
  function automatic logic [OUTLEN-1:0] scale_re(input logic [DATALEN-1:0] re);
    logic signed [DATALEN:0] s;
    s = ($signed({re[DATALEN-1], re}) + RND) >>> SCALESH;
`ifdef IFFT_SAT_EN
    if (s > SAT_HI)      s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
`endif
    return s[OUTLEN-1:0];
  endfunction

  always_comb begin
    for (int w = 0; w < NW; w++) unused_im[w*DATALEN +: DATALEN] = ifftout[w*2*DATALEN +: DATALEN];
  end

  always_comb begin
    state_d    = state_q;
    ochnl_d    = ochnl_q;
    beat_d     = beat_q;
    wren_d     = 1'b0;
    wraddr_d   = wraddr_q;
    wrdata_d   = wrdata_q;
    ifftdone_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      IDLE: begin
        ochnl_d = '0;
        beat_d  = '0;
        if (collstart) begin
          state_d   = ARM;
          overrun_d = 1'b0;
        end
      end
      ARM: if (ifftoutnext) state_d = CAPT;
      CAPT: begin
        wren_d   = 1'b1;
        wraddr_d = {3'b000, ochnl_q, beat_q};
        for (int w = 0; w < NW; w++)
          wrdata_d[w*OUTLEN +: OUTLEN] = scale_re(ifftout[w*2*DATALEN + DATALEN +: DATALEN]);
        if (ifftoutnext) overrun_d = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          if (ochnl_q == LAST_CH) begin
            state_d    = DONE;
            ifftdone_d = 1'b1;
          end else begin
            ochnl_d = ochnl_q + 6'd1;
            state_d = ARM;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write stage: one register between capture and the output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ochnl_q    <= '0;
      beat_q     <= '0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wrdata_q   <= '0;
      ifftdone_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ochnl_q    <= ochnl_d;
      beat_q     <= beat_d;
      wren_q     <= wren_d;
      wraddr_q   <= wraddr_d;
      wrdata_q   <= wrdata_d;
      ifftdone_q <= ifftdone_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wren     = wren_q;
  assign wraddr   = wraddr_q;
  assign wrdata   = wrdata_q;
  assign ifftdone = ifftdone_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_collect_ifft.sv
// Scoreboard bench for collect_ifft with four output channels per run; expected writes are
// queued as each beat is driven and matched (cycle, address, data, done) as the DUT writes.
module tb_collect_ifft;
  localparam int DATALEN = 16, OUTLEN = 8, PARATIL = 9, FFTCHNL = 8, NUMOCH = 4, SCALESH = 6;
  localparam int NW = PARATIL * FFTCHNL;

  logic                     clk = 1'b0;
  logic                     rst, collstart, ifftoutnext;
  logic [NW*2*DATALEN-1:0]  ifftout;
  logic                     wren;
  logic [11:0]              wraddr;
  logic [NW*OUTLEN-1:0]     wrdata;
  logic                     ifftdone, overrun;

  typedef struct {
    int                   cyc;
    logic [11:0]          addr;
    logic [NW*OUTLEN-1:0] data;
    logic                 done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0;

  collect_ifft #(.DATALEN(DATALEN), .OUTLEN(OUTLEN), .PARATIL(PARATIL), .FFTCHNL(FFTCHNL),
                 .NUMOCH(NUMOCH), .SCALESH(SCALESH)) dut (
    .clk(clk), .rst(rst), .collstart(collstart), .ifftoutnext(ifftoutnext), .ifftout(ifftout),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .ifftdone(ifftdone), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_f(input logic [15:0] re);
    int v;
    v = int'($signed(re));
    v = (v + (1 << (SCALESH - 1))) >>> SCALESH;
`ifdef IFFT_SAT_EN
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ifftdone) done_cnt++;
    if (wren) begin
      wr_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0d (no write expected)", wraddr);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc || wraddr !== e.addr || wrdata !== e.data || ifftdone !== e.done) begin
          fails++;
          $display("FAIL write cyc=%0d/%0d addr=%0d/%0d done=%b/%b data=%h exp %h",
                   cyc, e.cyc, wraddr, e.addr, ifftdone, e.done, wrdata, e.data);
        end
      end
    end else if (ifftdone) begin
      tests++;
      fails++;
      $display("FAIL done_without_write got ifftdone=1 required 0");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    collstart = 1'b1;
    idle(1);
    collstart = 1'b0;
  endtask

  // Drives one frame from an ARM slot; use_const puts cre in every word with expected byte cexp.
  task automatic send_frame(input int och, input bit last, input bit use_const,
                            input logic [15:0] cre, input logic [7:0] cexp,
                            input int ovr_beat, input int stop_beat);
    int P;
    exp_t e;
    logic [15:0] re, im;
    ifftoutnext = 1'b1;
    P = cyc + 1;
    idle(1);
    ifftoutnext = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == stop_beat) return;
      for (int w = 0; w < NW; w++) begin
        re = use_const ? cre : 16'($urandom);
        im = 16'($urandom);
        ifftout[w*32 +: 32] = {re, im};
        e.data[w*8 +: 8] = use_const ? cexp : model_f(re);
      end
      ifftoutnext = (b == ovr_beat);
      e.cyc  = P + 1 + b;
      e.addr = 12'(och * 8 + b);
      e.done = last && (b == 7);
      sb.push_back(e);
      idle(1);
    end
    ifftoutnext = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    tests += 5;
    if (wren !== 1'b0)       begin fails++; $display("FAIL %s_wren got %b required 0", tag, wren); end
    if (wraddr !== 12'd0)    begin fails++; $display("FAIL %s_wraddr got %0d required 0", tag, wraddr); end
    if (wrdata !== '0)       begin fails++; $display("FAIL %s_wrdata got %h required 0", tag, wrdata); end
    if (ifftdone !== 1'b0)   begin fails++; $display("FAIL %s_ifftdone got %b required 0", tag, ifftdone); end
    if (overrun !== 1'b0)    begin fails++; $display("FAIL %s_overrun got %b required 0", tag, overrun); end
  endtask

  task automatic check_run_end(input string tag, input int w0, input int d0);
    idle(3);
    tests += 3;
    if (sb.size() !== 0) begin fails++; $display("FAIL %s_pending got %0d writes outstanding required 0", tag, sb.size()); end
    if (wr_cnt - w0 !== 8 * NUMOCH) begin fails++; $display("FAIL %s_wrcount got %0d required %0d", tag, wr_cnt - w0, 8 * NUMOCH); end
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL %s_donecount got %0d required 1", tag, done_cnt - d0); end
  endtask

  task automatic test_reset();
    rst = 1'b1; collstart = 1'b0; ifftoutnext = 1'b0; ifftout = '0;
    idle(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_frames();
    int w0 = wr_cnt, d0 = done_cnt;
    start_run();
    for (int f = 0; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b1, 16'h0040, 8'h01, -1, -1);
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL frames_overrun got %b required 0", overrun); end
    check_run_end("frames", w0, d0);
  endtask

  task automatic test_rounding();
    logic [15:0] rv[4] = '{16'hFFE0, 16'hFFA0, 16'h0020, 16'h001F};
    logic [7:0]  ev[4] = '{8'h00, 8'hFF, 8'h01, 8'h00};
    int w0 = wr_cnt, d0 = done_cnt;
    start_run();
    for (int f = 0; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b1, rv[f], ev[f], -1, -1);
    check_run_end("rounding", w0, d0);
  endtask

  task automatic test_overflow();
    int w0 = wr_cnt, d0 = done_cnt;
    logic [7:0] e_pos, e_neg;
`ifdef IFFT_SAT_EN
    e_pos = 8'h7F; e_neg = 8'h80;
`else
    e_pos = 8'h00; e_neg = 8'h00;
`endif
    start_run();
    send_frame(0, 1'b0, 1'b1, 16'h7FFF, e_pos, -1, -1);
    send_frame(1, 1'b0, 1'b1, 16'h8000, e_neg, -1, -1);
    send_frame(2, 1'b0, 1'b0, 16'h0000, 8'h00, -1, -1);
    send_frame(3, 1'b1, 1'b0, 16'h0000, 8'h00, -1, -1);
    check_run_end("overflow", w0, d0);
  endtask

  task automatic test_overrun_back_to_back();
    int w0 = wr_cnt, d0 = done_cnt;
    start_run();
    send_frame(0, 1'b0, 1'b0, 16'h0000, 8'h00, 3, -1);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b required 1", overrun); end
    for (int f = 1; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b0, 16'h0000, 8'h00, -1, -1);
    check_run_end("overrun", w0, d0);
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b required 1", overrun); end
    w0 = wr_cnt; d0 = done_cnt;
    start_run();
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got %b required 0", overrun); end
    for (int f = 0; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b0, 16'h0000, 8'h00, -1, -1);
    check_run_end("back_to_back", w0, d0);
  endtask

  task automatic test_mid_reset();
    int w0, d0;
    start_run();
    send_frame(0, 1'b0, 1'b0, 16'h0000, 8'h00, -1, -1);
    send_frame(1, 1'b0, 1'b0, 16'h0000, 8'h00, 2, -1);
    send_frame(2, 1'b0, 1'b0, 16'h0000, 8'h00, -1, -1);
    send_frame(3, 1'b1, 1'b0, 16'h0000, 8'h00, -1, 4);
    rst = 1'b1;
    #2;
    check_outputs_zero("midreset");
    sb.delete();
    idle(2);
    rst = 1'b0;
    w0 = wr_cnt; d0 = done_cnt;
    ifftoutnext = 1'b1;
    idle(1);
    ifftoutnext = 1'b0;
    idle(12);
    tests++;
    if (wr_cnt !== w0) begin fails++; $display("FAIL midreset_idle_writes got %0d required 0", wr_cnt - w0); end
    start_run();
    for (int f = 0; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b1, 16'h0020, 8'h01, -1, -1);
    check_run_end("after_reset", w0, d0);
  endtask

  task automatic test_collstart_hold();
    int w0 = wr_cnt, d0 = done_cnt;
    collstart = 1'b1;
    idle(1);
    for (int f = 0; f < NUMOCH; f++) send_frame(f, f == NUMOCH - 1, 1'b0, 16'h0000, 8'h00, -1, -1);
    ifftoutnext = 1'b1;
    idle(1);
    collstart = 1'b0;
    ifftoutnext = 1'b0;
    idle(1);
    ifftoutnext = 1'b1;
    idle(1);
    ifftoutnext = 1'b0;
    idle(12);
    check_run_end("collstart_hold", w0, d0);
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL done_ifftoutnext_overrun got %b required 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_rounding();
    test_overflow();
    test_overrun_back_to_back();
    test_mid_reset();
    test_collstart_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
